// File: rtl/countdown_pkg.sv
// Shared definitions for the game countdown timer: state codes, default
// constants and the reload clamp helper.
package countdown_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RUN     = 2'd1;
  localparam state_t ST_PAUSED  = 2'd2;
  localparam state_t ST_EXPIRED = 2'd3;

  // 100 MHz system clock -> one decrement per second.
  localparam int GAME_TICK_DIV  = 100_000_000;
  localparam int DEFAULT_LOAD_C = 5;

  // Widest count supported by the clamp helper.
  localparam int MAX_CNT_W = 64;

  // A zero reload would expire instantly forever, so zero becomes one.
  function automatic logic [MAX_CNT_W-1:0] clamp_to_one(input logic [MAX_CNT_W-1:0] v);
    clamp_to_one = (v == '0) ? MAX_CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// The phase holds while en is low and returns to zero on clr or reset.
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc;

  assign tick = en && (presc == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      presc <= '0;
    end else if (en) begin
      if (presc == LAST) begin
        presc <= '0;
      end else begin
        presc <= presc + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Game countdown timer: prescaled down-counter with start, pause, runtime
// load and auto-reload. Optional warn output under COUNTDOWN_WARN_EN.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DEFAULT_LOAD = DEFAULT_LOAD_C,
  parameter int TICK_DIV     = GAME_TICK_DIV,
  parameter int WARN_THRESH  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_val,
  input  logic             auto_reload,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             done,
  output logic             expired
`ifdef COUNTDOWN_WARN_EN
  , output logic           warn
`endif
);

  localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEFAULT_LOAD);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] reload_reg, reload_n, count_n;
  logic [CNT_W-1:0] load_clamped;
  logic             done_n;
  logic             presc_en, presc_clr, tick, expiring;

  assign load_clamped = CNT_W'(clamp_to_one(MAX_CNT_W'(load_val)));

  // Start and load_en own the cycle, so the prescaler only advances on a
  // plain unpaused RUN cycle; that keeps tick and the count update aligned.
  assign presc_en  = (state == ST_RUN) && !pause && !start && !load_en;
  assign expiring  = tick && (count == ONE) && !auto_reload;
  assign presc_clr = start || expiring;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (presc_en),
    .clr   (presc_clr),
    .tick  (tick)
  );

  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload_reg;
    done_n   = 1'b0;
    if (start) begin
      state_n = ST_RUN;
      if (load_en) begin
        reload_n = load_clamped;
        count_n  = load_clamped;
      end else begin
        count_n  = reload_reg;
      end
    end else if (load_en) begin
      reload_n = load_clamped;
      if (state == ST_IDLE || state == ST_EXPIRED) begin
        count_n = load_clamped;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (pause) begin
            state_n = ST_PAUSED;
          end else if (tick) begin
            if (count > ONE) begin
              count_n = count - ONE;
            end else begin
              done_n = 1'b1;
              if (auto_reload) begin
                count_n = reload_reg;
              end else begin
                count_n = '0;
                state_n = ST_EXPIRED;
              end
            end
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_n = ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= DEF_VAL;
      reload_reg <= DEF_VAL;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      done       <= done_n;
    end
  end

  assign running = (state == ST_RUN);
  assign expired = (state == ST_EXPIRED);

`ifdef COUNTDOWN_WARN_EN
  localparam logic [CNT_W-1:0] WARN_VAL = CNT_W'(WARN_THRESH);

  // Computed from next-state values so warn lines up with the visible count.
  always_ff @(posedge clk) begin
    if (reset) begin
      warn <= 1'b0;
    end else begin
      warn <= (state_n == ST_RUN || state_n == ST_PAUSED) &&
              (count_n != '0) && (count_n <= WARN_VAL);
    end
  end
`endif

endmodule
